branch_resolve_queue: RTL
=========================

Name: branch_resolve_queue

Overview:
- In-order tracker for branch predictions in flight between fetch and execute.
- Fetch pushes each prediction (PC index, predicted direction). Execute later resolves the oldest one.
- The block drives the update side of the history table (enable, taken, PC index) and raises a registered mispredict/flush pulse.
- It discards all younger wrong-path entries on a mispredict and keeps a saturating mispredict counter.

Parameters:
- DEPTH, 4, number of outstanding predictions held (power of 2, ≥2).
- PC_W, 4, width of the history-table PC index.
- CNT_W, 16, width of the mispredict statistics counter.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- Pred_valid  input  1  fetch presents a prediction this cycle.
- Pred_PC  input  PC_W  history-table index of the predicted branch.
- Pred_taken  input  1  predicted direction (1 = taken).
- Pred_ready  output  1  queue accepts a push this cycle.
- Res_valid  input  1  execute resolves the oldest outstanding branch.
- Res_taken  input  1  actual direction.
- Update_en  output  1  one-cycle write strobe to the history table.
- Update_taken  output  1  actual direction for the update.
- Update_PC  output  PC_W  index of the entry to update.
- Mispredict  output  1  one-cycle pulse: resolution disagreed with prediction.
- Res_orphan  output  1  one-cycle pulse: Res_valid arrived with the queue empty.
- Occupancy  output  $clog2(DEPTH)+1  entries currently held.
- Mispredict_cnt  output  CNT_W  saturating mispredict count.

Behaviour:
- Reset (RST low, asynchronous):
  - Outputs: Update_en=0, Update_taken=0, Update_PC=0, Mispredict=0, Res_orphan=0, Occupancy=0, Mispredict_cnt=0.
  - Internal: head/tail pointers=0, state=RUN.
  - Queue contents don't-care.
- Reset asserted mid-operation abandons all entries. No update is emitted for them.
- State machine, two states:
  - RUN: pushes and resolutions are accepted.
  - FLUSH: entered on the edge after a mispredicting resolution. Lasts exactly one cycle, then returns to RUN.
- Pred_ready = (state==RUN) && (Occupancy<DEPTH). It is combinational from registered state only and does not look at same-cycle Res_valid.
- Push: Pred_valid && Pred_ready at a rising edge writes {Pred_PC, Pred_taken} at tail, and tail increments mod DEPTH.
- Pred_valid with Pred_ready=0 is dropped silently. The fetch side must hold it.
- Resolve, when Res_valid and Occupancy>0 at an edge:
  - Pop the head entry.
  - Next cycle: Update_en=1, Update_PC=head PC, Update_taken=Res_taken (1-cycle latency, registered).
  - If Res_taken != stored prediction, then also next cycle Mispredict=1 and Mispredict_cnt increments.
- Mispredict_cnt saturates at all-ones and never wraps.
- Flush on mispredict, at the same edge as the pop:
  - All remaining entries are discarded: Occupancy=0, head=tail.
  - Any push in that same cycle is also discarded.
  - State goes to FLUSH, so Pred_ready=0 for one cycle.
- Res_valid during FLUSH is treated as orphan: no pop, Res_orphan pulses next cycle.
- Res_valid with Occupancy==0 in RUN: no pop, no update, Res_orphan=1 next cycle.
- Simultaneous push and non-mispredicting pop:
  - Both take effect and Occupancy is unchanged.
  - When full, the push is not possible because Pred_ready=0.
- Simultaneous push and pop with the queue empty: the pop is an orphan. The new entry is not resolved by that Res_valid.
- Pointer wrap: head and tail wrap modulo DEPTH. Occupancy is tracked as an explicit counter, 0..DEPTH.
- Update_en, Mispredict and Res_orphan are single-cycle pulses and are 0 in every cycle without a qualifying event.

Test Plan:
- Reset check: assert RST low with queue half full → all outputs 0 immediately, without waiting for a clock edge. After release, Pred_ready=1 and Occupancy=0.
- In-order resolve, no mispredicts:
  - Push PC=3/T, PC=5/N, PC=9/T.
  - Resolve T, N, T → Update pulses carry PC 3/T, 5/N, 9/T in that order.
  - Mispredict stays 0 throughout; Occupancy ends at 0.
- Mispredict flush:
  - Push PC=2/T, 7/T, 11/N, then resolve N.
  - Next cycle → Update_en=1 with PC=2, taken=0; Mispredict=1; Mispredict_cnt=1; Occupancy=0.
  - Pred_ready=0 for one cycle, then 1.
  - Entries 7 and 11 are never updated.
- Full / backpressure:
  - Push 4 entries → Pred_ready=0 and a 5th push is ignored.
  - One resolve → Pred_ready=1 again.
  - Pointers wrap correctly across 10 push/pop pairs.
- Orphan cases:
  - Res_valid with queue empty → Res_orphan=1 for one cycle, Update_en=0.
  - Res_valid during the FLUSH cycle → same response.
- Counter saturation: preload (force) Mispredict_cnt to 0xFFFE, then cause 3 mispredicts → counter reads 0xFFFF and holds.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// In-order queue of branch predictions awaiting resolution. It drives the history-table
// update strobe, flags mispredicts and orphan resolutions, and counts mispredicts with saturation.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Pred_valid,
  input  logic [PC_W-1:0]          Pred_PC,
  input  logic                     Pred_taken,
  output logic                     Pred_ready,
  input  logic                     Res_valid,
  input  logic                     Res_taken,
  output logic                     Update_en,
  output logic                     Update_taken,
  output logic [PC_W-1:0]          Update_PC,
  output logic                     Mispredict,
  output logic                     Res_orphan,
  output logic [$clog2(DEPTH):0]   Occupancy,
  output logic [CNT_W-1:0]         Mispredict_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PC_W-1:0]  pc_mem    [DEPTH];
  logic             taken_mem [DEPTH];

  logic push;
  logic pop;
  logic orphan;
  logic mis;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign Pred_ready = (state == RUN) && (Occupancy != OCC_W'(DEPTH));

  always_comb begin
    push   = Pred_valid && Pred_ready;
    pop    = Res_valid && (state == RUN) && (Occupancy != '0);
    orphan = Res_valid && !pop;
    mis    = pop && (Res_taken != taken_mem[head]);
  end

  // Entry storage carries no reset; a push coinciding with a flush is thrown away
  always_ff @(posedge CLK) begin
    if (push && !mis) begin
      pc_mem[tail]    <= Pred_PC;
      taken_mem[tail] <= Pred_taken;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= RUN;
      head           <= '0;
      tail           <= '0;
      Occupancy      <= '0;
      Update_en      <= 1'b0;
      Update_taken   <= 1'b0;
      Update_PC      <= '0;
      Mispredict     <= 1'b0;
      Res_orphan     <= 1'b0;
      Mispredict_cnt <= '0;
    end else begin
      Update_en  <= pop;
      Mispredict <= mis;
      Res_orphan <= orphan;
      if (pop) begin
        Update_PC    <= pc_mem[head];
        Update_taken <= Res_taken;
      end
      if (mis) begin
        // Wrong-path entries behind the mispredicted branch are dropped wholesale
        Mispredict_cnt <= sat_inc(Mispredict_cnt);
        state          <= FLUSH;
        head           <= tail;
        Occupancy      <= '0;
      end else begin
        state <= RUN;
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   Occupancy <= Occupancy + 1'b1;
          2'b01:   Occupancy <= Occupancy - 1'b1;
          default: Occupancy <= Occupancy;
        endcase
      end
    end
  end

endmodule
